// File: rtl/ld_imm_sequencer.sv
// -----------------------------------------------------------------------------
// ld_imm_sequencer
// Microcode sequencer for the immediate-load instruction family:
//   LD r,d8   (mode 2'b00) : one PC read, byte written to Dest_Lo
//   LD (HL),d8(mode 2'b01) : PC read into temp, then temp written to (HL)
//   LD rr,d16 (mode 2'b10) : two PC reads, low byte to Dest_Lo, high to Dest_Hi
//   mode 2'b11             : illegal, one-cycle o_Illegal pulse
// The block keeps its own T-step counter and M-cycle state and decodes the
// bus/register strobes from them. Each M-cycle lasts STEPS T-steps: the
// address is driven at ADDR_STEP and data moves at DATA_STEP (= STEPS-1).
//
// Optional feature: define LD_IMM_WAIT_EN to let i_Mem_Ready=0 stall the
// sequence at DATA_STEP. Without it i_Mem_Ready is ignored.
//
// Ports
//   i_Clk, i_Rst_n     clock, synchronous active-low reset
//   i_Start            one-cycle start pulse from the decoder
//   i_Mode             instruction variant (see above)
//   i_Dest_Lo/Hi       one-hot destination registers, latched at start
//   i_Mem_Ready        memory ready (only with LD_IMM_WAIT_EN)
//   o_Busy, o_M_Cycle  sequence status (M-cycle 0 idle, 1..2)
//   o_Address_Out, o_Addr_Sel, o_PC_Inc           address-side strobes
//   o_Bus_In, o_Bus_Out                           data bus direction
//   o_Write8, o_Temp_Write, o_Move_Reg            register-side strobes
//   o_IR_Fetch         request next opcode fetch (last data step)
//   o_Illegal          one-cycle pulse for mode 2'b11
// -----------------------------------------------------------------------------
module ld_imm_sequencer #(
    parameter int NUM_REGS  = 8,
    parameter int STEPS     = 4,
    parameter int ADDR_STEP = 1,
    parameter int DATA_STEP = 3
) (
    input  logic                i_Clk,
    input  logic                i_Rst_n,
    input  logic                i_Start,
    input  logic [1:0]          i_Mode,
    input  logic [NUM_REGS-1:0] i_Dest_Lo,
    input  logic [NUM_REGS-1:0] i_Dest_Hi,
    input  logic                i_Mem_Ready,
    output logic                o_Busy,
    output logic [1:0]          o_M_Cycle,
    output logic                o_Address_Out,
    output logic                o_Addr_Sel,
    output logic                o_PC_Inc,
    output logic                o_Bus_In,
    output logic                o_Bus_Out,
    output logic [NUM_REGS-1:0] o_Write8,
    output logic                o_Temp_Write,
    output logic                o_Move_Reg,
    output logic                o_IR_Fetch,
    output logic                o_Illegal
);

    localparam int TW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam logic [TW-1:0] ADDR_T = TW'(ADDR_STEP);
    localparam logic [TW-1:0] DATA_T = TW'(DATA_STEP);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_IMM_LO  = 3'd1,
        S_IMM_HI  = 3'd2,
        S_MEM_WR  = 3'd3,
        S_ILLEGAL = 3'd4
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [TW-1:0]       r_t;
    logic [TW-1:0]       w_t_nxt;
    logic [1:0]          r_mode;
    logic [NUM_REGS-1:0] r_dest_lo;
    logic [NUM_REGS-1:0] r_dest_hi;

    logic w_accept;
    logic w_active;
    logic w_addr_step;
    logic w_data_step;
    logic w_ready;

`ifdef LD_IMM_WAIT_EN
    assign w_ready = i_Mem_Ready;
`else
    // Ready is deliberately ignored here; the OR keeps the port referenced.
    assign w_ready = 1'b1 | i_Mem_Ready;
`endif

    // Starts are only taken from IDLE, so busy and illegal cycles drop them.
    assign w_accept    = (r_state == S_IDLE) && i_Start;
    assign w_active    = (r_state == S_IMM_LO) || (r_state == S_IMM_HI) ||
                         (r_state == S_MEM_WR);
    assign w_addr_step = (r_t == ADDR_T);
    assign w_data_step = (r_t == DATA_T);

    // State, T-step and latched instruction fields.
    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            r_state   <= S_IDLE;
            r_t       <= '0;
            r_mode    <= 2'b00;
            r_dest_lo <= '0;
            r_dest_hi <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_t     <= w_t_nxt;
            if (w_accept) begin
                r_mode    <= i_Mode;
                r_dest_lo <= i_Dest_Lo;
                r_dest_hi <= i_Dest_Hi;
            end else begin
                r_mode    <= r_mode;
                r_dest_lo <= r_dest_lo;
                r_dest_hi <= r_dest_hi;
            end
        end
    end

    // Next-state, T-step advance and strobe decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_t_nxt       = r_t;
        o_Busy        = 1'b0;
        o_M_Cycle     = 2'd0;
        o_Address_Out = 1'b0;
        o_Addr_Sel    = 1'b0;
        o_PC_Inc      = 1'b0;
        o_Bus_In      = 1'b0;
        o_Bus_Out     = 1'b0;
        o_Write8      = '0;
        o_Temp_Write  = 1'b0;
        o_Move_Reg    = 1'b0;
        o_IR_Fetch    = 1'b0;
        o_Illegal     = 1'b0;

        if (i_Rst_n) begin
            case (r_state)
                S_IDLE: begin
                    if (i_Start) begin
                        if (i_Mode == 2'b11) begin
                            w_state_nxt = S_ILLEGAL;
                        end else begin
                            w_state_nxt = S_IMM_LO;
                        end
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
                S_IMM_LO: begin
                    o_Busy        = 1'b1;
                    o_M_Cycle     = 2'd1;
                    o_Address_Out = w_addr_step;
                    o_PC_Inc      = w_addr_step;
                    o_Bus_In      = w_data_step;
                    // Register-side strobes fire only on the ready data step.
                    if (w_data_step && w_ready) begin
                        case (r_mode)
                            2'b00: begin
                                o_Write8    = r_dest_lo;
                                o_IR_Fetch  = 1'b1;
                                w_state_nxt = S_IDLE;
                            end
                            2'b01: begin
                                o_Temp_Write = 1'b1;
                                w_state_nxt  = S_MEM_WR;
                            end
                            2'b10: begin
                                o_Write8    = r_dest_lo;
                                w_state_nxt = S_IMM_HI;
                            end
                            default: begin
                                w_state_nxt = S_IDLE;
                            end
                        endcase
                    end else begin
                        w_state_nxt = S_IMM_LO;
                    end
                end
                S_IMM_HI: begin
                    o_Busy        = 1'b1;
                    o_M_Cycle     = 2'd2;
                    o_Address_Out = w_addr_step;
                    o_PC_Inc      = w_addr_step;
                    o_Bus_In      = w_data_step;
                    if (w_data_step && w_ready) begin
                        o_Write8    = r_dest_hi;
                        o_IR_Fetch  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_IMM_HI;
                    end
                end
                S_MEM_WR: begin
                    o_Busy        = 1'b1;
                    o_M_Cycle     = 2'd2;
                    o_Addr_Sel    = 1'b1;
                    o_Address_Out = w_addr_step;
                    o_Bus_Out     = w_data_step;
                    o_Move_Reg    = w_data_step;
                    if (w_data_step && w_ready) begin
                        o_IR_Fetch  = 1'b1;
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_MEM_WR;
                    end
                end
                S_ILLEGAL: begin
                    o_Illegal   = 1'b1;
                    w_state_nxt = S_IDLE;
                end
                default: begin
                    w_state_nxt = S_IDLE;
                end
            endcase

            // T-step wraps at the data step; an unready data step holds it.
            if (w_active) begin
                if (w_data_step) begin
                    if (w_ready) begin
                        w_t_nxt = '0;
                    end else begin
                        w_t_nxt = r_t;
                    end
                end else begin
                    w_t_nxt = r_t + TW'(1);
                end
            end else begin
                w_t_nxt = '0;
            end
        end else begin
            // Reset cycle: all strobes stay low and the sequence is dropped.
            w_state_nxt = S_IDLE;
            w_t_nxt     = '0;
        end
    end

endmodule
